// File: rtl/core6502_pkg.sv
// Shared Core6502 definitions: sequencer state encoding, opcode class masks
// and the BRK opcode used for interrupt and reset injection.
package core6502_pkg;

    typedef enum logic [1:0] {
        ST_OPREAD = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } seq_state_t;

    localparam logic [7:0] BRK_OPCODE = 8'h00;

    // Each class term is "(opcode & MASK) == MATCH".
    localparam logic [7:0] IMPL_MASK     = 8'b0000_1101;
    localparam logic [7:0] IMPL_MATCH    = 8'b0000_1000;
    localparam logic [7:0] TC_IMM_MASK   = 8'b0001_1101;
    localparam logic [7:0] TC_IMM_MATCH  = 8'b0000_1001;
    localparam logic [7:0] TC_XIMM_MASK  = 8'b1001_1101;
    localparam logic [7:0] TC_XIMM_MATCH = 8'b1000_0000;
    localparam logic [7:0] STACK_MASK    = 8'b1001_0010;
    localparam logic [7:0] STACK_MATCH   = 8'b0000_0000;

    function automatic logic opMatch(input logic [7:0] op,
                                     input logic [7:0] mask,
                                     input logic [7:0] match);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/pd_classify.sv
// Combinational opcode classifier: flags implied/accumulator opcodes and
// opcodes that complete in two cycles. Shared with the trace monitor.
module pd_classify
    import core6502_pkg::*;
(
    input  logic [7:0] pd_i,
    output logic       twoCycle_o,
    output logic       impl_o
);

    logic isImpl;
    logic isImm;
    logic isXImm;
    logic isStack;

    assign isImpl  = opMatch(pd_i, IMPL_MASK,    IMPL_MATCH);
    assign isImm   = opMatch(pd_i, TC_IMM_MASK,  TC_IMM_MATCH);
    assign isXImm  = opMatch(pd_i, TC_XIMM_MASK, TC_XIMM_MATCH);
    // PHP/PLP/PHA/PLA are implied but need stack cycles.
    assign isStack = opMatch(pd_i, STACK_MASK,   STACK_MATCH);

    assign impl_o     = isImpl;
    assign twoCycle_o = isImm | isXImm | (isImpl & ~isStack);

endmodule

// File: rtl/predecode_seq.sv
// Predecode latch and opcode fetch sequencer: latches the data bus, injects
// BRK when an interrupt or reset is pending and raises FETCH in DECODE.
module predecode_seq
    import core6502_pkg::*;
#(
    parameter int TCNT_W = 3
) (
    input  logic              PHI0,
    input  logic              RES,
    input  logic              RDY,
    input  logic [7:0]        DB,
    input  logic              ENDS,
    input  logic              INTR,
    output logic [7:0]        n_PD,
    output logic              FETCH,
    output logic              TWOCYCLE,
    output logic              IMPL,
    output logic              INJ,
    output logic [TCNT_W-1:0] TCNT
);

    localparam logic [TCNT_W-1:0] TCNT_MAX = {TCNT_W{1'b1}};

    seq_state_t        state_q, state_d;
    logic [7:0]        pd_q, pd_d;
    logic              inj_q, inj_d;
    logic              injOut_q, injOut_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    always_comb begin
        state_d  = state_q;
        pd_d     = DB;
        inj_d    = inj_q;
        injOut_d = 1'b0;
        tcnt_d   = tcnt_q;
        case (state_q)
            ST_OPREAD: begin
                state_d  = ST_DECODE;
                tcnt_d   = TCNT_W'(1);
                injOut_d = inj_q;
                if (inj_q) begin
                    pd_d  = BRK_OPCODE;
                    inj_d = 1'b0;
                end
            end
            ST_DECODE, ST_EXEC: begin
                if (ENDS) begin
                    state_d = ST_OPREAD;
                    tcnt_d  = '0;
                    // A pending injection absorbs any further INTR.
                    if (INTR) inj_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                    if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OPREAD;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PHI0) begin
        if (RES) begin
            state_q  <= ST_OPREAD;
            pd_q     <= BRK_OPCODE;
            inj_q    <= 1'b1;
            injOut_q <= 1'b0;
            tcnt_q   <= '0;
        end else if (RDY) begin
            state_q  <= state_d;
            pd_q     <= pd_d;
            inj_q    <= inj_d;
            injOut_q <= injOut_d;
            tcnt_q   <= tcnt_d;
        end
    end

    pd_classify uClassify (
        .pd_i       (pd_q),
        .twoCycle_o (TWOCYCLE),
        .impl_o     (IMPL)
    );

    assign n_PD  = ~pd_q;
    assign FETCH = (state_q == ST_DECODE);
    assign INJ   = injOut_q;
    assign TCNT  = tcnt_q;

endmodule

// File: tb/tb_predecode_seq.sv
// Directed bench for predecode_seq with hand-computed expectations.
module tb_predecode_seq;

    logic       PHI0 = 1'b0;
    logic       RES, RDY, ENDS, INTR;
    logic [7:0] DB;
    logic [7:0] n_PD;
    logic       FETCH, TWOCYCLE, IMPL, INJ;
    logic [2:0] TCNT;

    int compared = 0;
    int mismatched = 0;

    predecode_seq #(.TCNT_W(3)) dut (
        .PHI0     (PHI0),
        .RES      (RES),
        .RDY      (RDY),
        .DB       (DB),
        .ENDS     (ENDS),
        .INTR     (INTR),
        .n_PD     (n_PD),
        .FETCH    (FETCH),
        .TWOCYCLE (TWOCYCLE),
        .IMPL     (IMPL),
        .INJ      (INJ),
        .TCNT     (TCNT)
    );

    always #5 PHI0 = ~PHI0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, lets one edge pass, then settles before sampling.
    task automatic applyStimulus(input logic res, input logic rdy, input logic [7:0] db,
                                 input logic ends, input logic intr);
        RES = res; RDY = rdy; DB = db; ENDS = ends; INTR = intr;
        @(posedge PHI0);
        #2;
    endtask

    task automatic checkDecode(input string tag, input int npd, input int tc,
                               input int impl, input int inj);
        checkOutput({tag, ".fetch"}, FETCH, 1);
        checkOutput({tag, ".npd"}, n_PD, npd);
        checkOutput({tag, ".tc"}, TWOCYCLE, tc);
        checkOutput({tag, ".impl"}, IMPL, impl);
        checkOutput({tag, ".inj"}, INJ, inj);
        checkOutput({tag, ".tcnt"}, TCNT, 1);
    endtask

    logic [7:0] opTab [3] = '{8'h48, 8'hE8, 8'hA2};
    logic [7:0] npdTab [3] = '{8'hB7, 8'h17, 8'h5D};
    int implTab [3] = '{1, 1, 0};
    int tcTab [3] = '{0, 1, 1};

    initial begin
        RES = 1'b1; RDY = 1'b1; DB = 8'h00; ENDS = 1'b0; INTR = 1'b0;
        #1;

        applyStimulus(1, 1, 8'h00, 0, 0);
        checkOutput("rst.npd", n_PD, 8'hFF);
        checkOutput("rst.fetch", FETCH, 0);
        checkOutput("rst.tcnt", TCNT, 0);
        checkOutput("rst.inj", INJ, 0);
        checkOutput("rst.tc", TWOCYCLE, 0);
        checkOutput("rst.impl", IMPL, 0);

        applyStimulus(0, 1, 8'hA9, 0, 0);
        checkDecode("rstbrk", 8'hFF, 0, 0, 1);
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("rstbrk.end.fetch", FETCH, 0);

        applyStimulus(0, 1, 8'hA9, 1, 0);
        checkDecode("lda", 8'h56, 1, 0, 0);
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("lda.end.fetch", FETCH, 0);
        checkOutput("lda.end.tcnt", TCNT, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, opTab[i], 0, 0);
            checkDecode($sformatf("op%0h", opTab[i]), npdTab[i], tcTab[i], implTab[i], 0);
            applyStimulus(0, 1, 8'h00, 1, 0);
        end

        // Four-cycle op ending with an interrupt at TCNT=3.
        applyStimulus(0, 1, 8'hAD, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkOutput("four.t2", TCNT, 2);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("four.t3", TCNT, 3);
        applyStimulus(0, 1, 8'h00, 1, 1);
        checkOutput("four.end.tcnt", TCNT, 0);
        checkOutput("four.end.fetch", FETCH, 0);
        applyStimulus(0, 1, 8'hEA, 0, 0);
        checkDecode("irqbrk", 8'hFF, 0, 0, 1);
        applyStimulus(0, 1, 8'h00, 1, 0);
        applyStimulus(0, 1, 8'hEA, 0, 0);
        checkDecode("nop", 8'h15, 1, 1, 0);
        applyStimulus(0, 1, 8'h00, 1, 0);

        // Stretched DECODE.
        applyStimulus(0, 1, 8'hA9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h12, 1, 1);
            checkDecode($sformatf("stall%0d", i), 8'h56, 1, 0, 0);
        end
        applyStimulus(0, 1, 8'h12, 0, 0);
        checkOutput("resume.fetch", FETCH, 0);
        checkOutput("resume.tcnt", TCNT, 2);

        // INTR without ENDS must not inject.
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("intrnoends.tcnt", TCNT, 0);
        applyStimulus(0, 1, 8'hA9, 0, 0);
        checkDecode("intrnoends", 8'h56, 1, 0, 0);

        // Reset mid-instruction at TCNT=5.
        applyStimulus(0, 1, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("midrst.t5", TCNT, 5);
        applyStimulus(1, 1, 8'h00, 0, 0);
        checkOutput("midrst.tcnt", TCNT, 0);
        checkOutput("midrst.npd", n_PD, 8'hFF);
        checkOutput("midrst.fetch", FETCH, 0);
        applyStimulus(0, 1, 8'hA9, 0, 0);
        checkDecode("midrst.brk", 8'hFF, 0, 0, 1);

        // TCNT saturation, then RES colliding with ENDS and INTR.
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("sat.tcnt", TCNT, 7);
        applyStimulus(1, 0, 8'hA9, 1, 1);
        checkOutput("collide.tcnt", TCNT, 0);
        checkOutput("collide.fetch", FETCH, 0);
        checkOutput("collide.npd", n_PD, 8'hFF);
        applyStimulus(0, 1, 8'hA9, 1, 0);
        checkDecode("collide.brk", 8'hFF, 0, 0, 1);
        applyStimulus(0, 1, 8'h00, 1, 0);
        applyStimulus(0, 1, 8'hA2, 1, 0);
        checkDecode("collide.next", 8'h5D, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
